// File: rtl/gascon_pkg.sv
// Shared types and defaults for the GASCON permutation controller.
// No logic here; imported by the controller and its round counter.
package gascon_pkg;

    localparam int CWIDTH_DEF     = 320;
    localparam int MAX_ROUNDS_DEF = 12;
    localparam int TIMEOUT_DEF    = 64;

    typedef logic [CWIDTH_DEF-1:0] gascon_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } gascon_ctrl_state_e;

endpackage

// File: rtl/gascon_round_counter.sv
// Rounds-remaining / round-constant-index counter for the permutation controller.
// Latency: registered, updates the cycle after load or step.
// Backpressure: none; the controller decides when to load and step.
module gascon_round_counter
    import gascon_pkg::*;
#(
    parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
    parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [RW-1:0] load_n,
    input  logic          step,
    output logic [RW-1:0] idx,
    output logic          last
);

    logic [RW-1:0] n_q;
    logic [RW-1:0] idx_q;

    // A job of n rounds uses the final n round constants: MAX_ROUNDS-n .. MAX_ROUNDS-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q   <= '0;
            idx_q <= '0;
        end else if (load) begin
            n_q   <= load_n;
            idx_q <= RW'(MAX_ROUNDS) - load_n;
        end else if (step) begin
            n_q   <= n_q - 1'b1;
            idx_q <= idx_q + 1'b1;
        end
    end

    assign idx  = idx_q;
    assign last = (n_q == RW'(1));

endmodule

// File: rtl/gascon_perm_ctrl.sv
// Sequences an n-round GASCON permutation over one shared round core (optional watchdog: GASCON_CTRL_WATCHDOG_EN).
// Latency: R*(L+1)+1 cycles from input handshake to out_valid (R rounds, L core latency; R=0 gives 1).
// Backpressure: in_ready only in IDLE; out_state held in DONE until out_ready.
module gascon_perm_ctrl
    import gascon_pkg::*;
#(
    parameter int CWIDTH     = CWIDTH_DEF,
    parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
`ifdef GASCON_CTRL_WATCHDOG_EN
    parameter int TIMEOUT    = TIMEOUT_DEF,
`endif
    parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CWIDTH-1:0] in_state,
    input  logic [RW-1:0]     in_rounds,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] out_state,
    output logic [CWIDTH-1:0] rnd_c,
    output logic [RW-1:0]     rnd_idx,
    output logic              rnd_start,
    input  logic [CWIDTH-1:0] rnd_cout,
    input  logic              rnd_done,
    output logic              busy,
    output logic              err
);

    gascon_ctrl_state_e state_q, state_d;
    logic [CWIDTH-1:0]  st_q;
    logic [RW-1:0]      rounds_sat;
    logic               in_fire;
    logic               step;
    logic               last;
    logic               wd_expire;

    assign rounds_sat = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;
    assign in_fire    = (state_q == IDLE) && in_valid;
    assign step       = (state_q == WAIT) && rnd_done;

    gascon_round_counter #(
        .MAX_ROUNDS (MAX_ROUNDS),
        .RW         (RW)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (in_fire),
        .load_n (rounds_sat),
        .step   (step),
        .idx    (rnd_idx),
        .last   (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                st_q <= in_state;
            end else if (step) begin
                st_q <= rnd_cout;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rnd_start = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = (rounds_sat == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                rnd_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (rnd_done) begin
                    state_d = last ? DONE : ISSUE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // st_q doubles as the core operand and the result; it only moves on load or rnd_done.
    assign rnd_c     = st_q;
    assign out_state = st_q;

`ifdef GASCON_CTRL_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q;
    logic           err_q;

    // Expires on the TIMEOUT-th consecutive WAIT cycle without rnd_done.
    assign wd_expire = (state_q == WAIT) && !rnd_done && (wd_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wd_q <= '0;
            end else if (state_q == WAIT) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_gascon_perm_ctrl.sv
// Bench for gascon_perm_ctrl: behavioural round-core model with random latency,
// random jobs checked against a golden n-round permutation computed directly.
module tb_gascon_perm_ctrl;

    localparam int CW = 320;
    localparam int MR = 12;
    localparam int RW = 4;

    typedef logic [CW-1:0] st_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    st_t           in_state;
    logic [RW-1:0] in_rounds;
    logic          out_valid;
    logic          out_ready;
    st_t           out_state;
    st_t           rnd_c;
    logic [RW-1:0] rnd_idx;
    logic          rnd_start;
    st_t           rnd_cout;
    logic          rnd_done;
    logic          busy;
    logic          err;

    gascon_perm_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_rounds (in_rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .rnd_c     (rnd_c),
        .rnd_idx   (rnd_idx),
        .rnd_start (rnd_start),
        .rnd_cout  (rnd_cout),
        .rnd_done  (rnd_done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            core_lat  = 1;
    bit            core_hold = 1'b0;
    int            core_cnt  = 0;
    st_t           core_c;
    logic [RW-1:0] core_idx;
    int            idx_q[$];

    // Stand-in round function: rotate by one, xor a round-index dependent constant.
    function automatic st_t rf(input st_t c, input int idx);
        st_t k;
        for (int w = 0; w < CW / 32; w++) begin
            k[w*32 +: 32] = (32'h9e3779b9 * 32'(idx + 1)) ^ 32'(w);
        end
        return {c[CW-2:0], c[CW-1]} ^ k;
    endfunction

    function automatic st_t golden(input st_t s, input int rounds);
        int  n;
        st_t r;
        n = (rounds > MR) ? MR : rounds;
        r = s;
        for (int i = MR - n; i < MR; i++) r = rf(r, i);
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int w = 0; w < CW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Round core model: answers L cycles after the cycle in which rnd_start is seen.
    always @(negedge clk) begin
        if (!reset) begin
            core_cnt = 0;
            rnd_done = 1'b0;
        end else begin
            rnd_done = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    rnd_done = 1'b1;
                    rnd_cout = rf(core_c, int'(core_idx));
                end
            end
            if (rnd_start) begin
                idx_q.push_back(int'(rnd_idx));
                core_c   = rnd_c;
                core_idx = rnd_idx;
                if (!core_hold) core_cnt = core_lat;
            end
        end
    end

    task automatic chk(input string tag, input st_t obs, input st_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_job(input st_t s, input int rounds, input int lat, input int hold);
        int  n;
        int  cyc;
        bit  ok;
        st_t exp;
        n   = (rounds > MR) ? MR : rounds;
        exp = golden(s, rounds);
        core_lat = lat;
        idx_q.delete();
        @(negedge clk);
        in_state  = s;
        in_rounds = RW'(rounds);
        in_valid  = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_idle", st_t'(in_ready), st_t'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_state = rand_state();
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 2000 && !ok) begin
            @(negedge clk);
            cyc++;
            ok = out_valid;
        end
        chk("latency", st_t'(cyc), st_t'(n * (lat + 1) + 1));
        chk("out_state", out_state, exp);
        chk("start_count", st_t'(idx_q.size()), st_t'(n));
        for (int i = 0; i < idx_q.size() && i < n; i++) begin
            chk("rnd_idx_seq", st_t'(idx_q[i]), st_t'(MR - n + i));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", st_t'(out_valid), st_t'(1));
            chk("hold_out_state", out_state, exp);
            chk("hold_in_ready", st_t'(in_ready), st_t'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", st_t'(out_valid), st_t'(0));
        chk("in_ready_back", st_t'(in_ready), st_t'(1));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        st_t s;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_rounds = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", st_t'(in_ready), st_t'(1));
        chk("rst_busy", st_t'(busy), st_t'(0));
        chk("rst_out_valid", st_t'(out_valid), st_t'(0));
        chk("rst_rnd_start", st_t'(rnd_start), st_t'(0));
        chk("rst_err", st_t'(err), st_t'(0));
        chk("rst_out_state", out_state, st_t'(0));
        chk("rst_rnd_c", rnd_c, st_t'(0));
        reset = 1'b1;

        do_job(rand_state(), 0, 1, 0);
        do_job(rand_state(), 12, 1, 0);
        do_job(rand_state(), 6, 1, 0);
        do_job(rand_state(), 15, 1, 0);
        do_job(rand_state(), 4, 3, 10);
        for (int j = 0; j < 8; j++) begin
            do_job(rand_state(), int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 3)));
        end

        // Reset in the WAIT phase of round 3.
        core_lat = 2;
        idx_q.delete();
        @(negedge clk);
        in_state  = rand_state();
        in_rounds = RW'(12);
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (idx_q.size() < 3 && cyc < 200) begin
            @(negedge clk);
            #1 cyc++;
        end
        chk("reach_round3", st_t'(idx_q.size()), st_t'(3));
        @(posedge clk);
        #1;
        chk("in_wait_no_start", st_t'(rnd_start), st_t'(0));
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", st_t'(in_ready), st_t'(1));
        chk("mid_rst_busy", st_t'(busy), st_t'(0));
        chk("mid_rst_out_valid", st_t'(out_valid), st_t'(0));
        chk("mid_rst_rnd_start", st_t'(rnd_start), st_t'(0));
        chk("mid_rst_out_state", out_state, st_t'(0));
        chk("mid_rst_rnd_c", rnd_c, st_t'(0));
        chk("mid_rst_rnd_idx", st_t'(rnd_idx), st_t'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("dropped_job_silent", st_t'(seen), st_t'(0));
        do_job(rand_state(), 9, 2, 1);

`ifdef GASCON_CTRL_WATCHDOG_EN
        core_hold = 1'b1;
        @(negedge clk);
        s         = rand_state();
        in_state  = s;
        in_rounds = RW'(5);
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!err && cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (out_valid) seen = 1'b1;
        end
        chk("wd_err", st_t'(err), st_t'(1));
        chk("wd_not_early", st_t'(cyc >= 64), st_t'(1));
        chk("wd_idle", st_t'(in_ready), st_t'(1));
        chk("wd_busy", st_t'(busy), st_t'(0));
        chk("wd_no_out", st_t'(seen), st_t'(0));
        core_hold = 1'b0;
        do_job(rand_state(), 3, 1, 0);
        chk("wd_err_sticky", st_t'(err), st_t'(1));
`else
        chk("err_tied_0", st_t'(err), st_t'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
